// File: rtl/mul_rs_scheduler.sv
// mul_rs_scheduler
//   Issue scheduler for the multiply/divide unit. Picks one ready MUL/DIV
//   reservation-station entry (round-robin by default), strobes the exec unit,
//   counts the fixed latency, then holds a CDB request until granted and
//   frees the entry. One operation in flight at a time.
//
//   Optional macro MUL_SCHED_FIXED_PRI_EN: lowest eligible index always wins
//   and no round-robin pointer exists.
//
// Ports
//   clk2, rst (async, active high), flush (sync abort)
//   rs_valid/rs_ready [NUM_RS], rs_func_flat/rs_rd_flat [4*NUM_RS],
//   rs_rob_flat [3*NUM_RS]          : reservation-station view
//   ex_b, ex_idx, ex_func, ex_rd, ex_rob : start strobe + latched entry
//   busy                            : EXEC or WB
//   cdb_req / cdb_gnt               : write-back handshake
//   rs_free [NUM_RS]                : one-hot entry release pulse
module mul_rs_scheduler #(
  parameter int NUM_RS  = 3,
  parameter int IDX_W   = 2,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic                clk2,
  input  logic                rst,
  input  logic                flush,
  input  logic [NUM_RS-1:0]   rs_valid,
  input  logic [NUM_RS-1:0]   rs_ready,
  input  logic [4*NUM_RS-1:0] rs_func_flat,
  input  logic [4*NUM_RS-1:0] rs_rd_flat,
  input  logic [3*NUM_RS-1:0] rs_rob_flat,
  output logic                ex_b,
  output logic [IDX_W-1:0]    ex_idx,
  output logic [3:0]          ex_func,
  output logic [3:0]          ex_rd,
  output logic [2:0]          ex_rob,
  output logic                busy,
  output logic                cdb_req,
  input  logic                cdb_gnt,
  output logic [NUM_RS-1:0]   rs_free
);

  localparam logic [3:0] FUNC_MUL = 4'b0010;
  localparam logic [3:0] FUNC_DIV = 4'b0011;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         func_q, func_d;
  logic [3:0]         rd_q, rd_d;
  logic [2:0]         rob_q, rob_d;
  logic               ex_b_q, ex_b_d;
  logic               cdb_req_q, cdb_req_d;
  logic [NUM_RS-1:0]  rs_free_q, rs_free_d;

  logic [NUM_RS-1:0]  eligible;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [3:0]         sel_func;

  always_comb begin
    for (int i = 0; i < NUM_RS; i++) begin
      eligible[i] = rs_valid[i] & rs_ready[i] &
                    ((rs_func_flat[4*i +: 4] == FUNC_MUL) ||
                     (rs_func_flat[4*i +: 4] == FUNC_DIV));
    end
  end

`ifdef MUL_SCHED_FIXED_PRI_EN
  // Scan high to low so the lowest eligible index is the last one written.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_RS-1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // First eligible entry starting at rr_ptr, wrapping modulo NUM_RS.
  always_comb begin
    int j;
    j         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      j = (int'(rr_ptr_q) + k) % NUM_RS;
      if (!sel_found && eligible[j]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(j);
      end
    end
  end

  // Pointer only moves on issue; a flush leaves it alone.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (!flush && state_q == S_IDLE && sel_found)
      rr_ptr_d = (sel_idx == IDX_W'(NUM_RS-1)) ? '0 : sel_idx + 1'b1;
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign sel_func = rs_func_flat[4*sel_idx +: 4];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    func_d    = func_q;
    rd_d      = rd_q;
    rob_d     = rob_q;
    ex_b_d    = 1'b0;
    cdb_req_d = cdb_req_q;
    rs_free_d = '0;
    if (flush) begin
      state_d   = S_IDLE;
      cdb_req_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_found) begin
            state_d = S_EXEC;
            ex_b_d  = 1'b1;
            idx_d   = sel_idx;
            func_d  = sel_func;
            rd_d    = rs_rd_flat[4*sel_idx +: 4];
            rob_d   = rs_rob_flat[3*sel_idx +: 3];
            cnt_d   = (sel_func == FUNC_DIV) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
          end
        end
        S_EXEC: begin
          // Counter holds LAT in the ex_b cycle; leaving at 1 lands cdb_req
          // exactly LAT cycles after ex_b.
          if (cnt_q <= CNT_W'(1)) begin
            state_d   = S_WB;
            cdb_req_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_WB: begin
          if (cdb_gnt) begin
            state_d   = S_IDLE;
            cdb_req_d = 1'b0;
            for (int i = 0; i < NUM_RS; i++)
              if (IDX_W'(i) == idx_q) rs_free_d[i] = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      func_q    <= '0;
      rd_q      <= '0;
      rob_q     <= '0;
      ex_b_q    <= 1'b0;
      cdb_req_q <= 1'b0;
      rs_free_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      func_q    <= func_d;
      rd_q      <= rd_d;
      rob_q     <= rob_d;
      ex_b_q    <= ex_b_d;
      cdb_req_q <= cdb_req_d;
      rs_free_q <= rs_free_d;
    end
  end

  assign ex_b    = ex_b_q;
  assign ex_idx  = idx_q;
  assign ex_func = func_q;
  assign ex_rd   = rd_q;
  assign ex_rob  = rob_q;
  assign busy    = (state_q != S_IDLE);
  assign cdb_req = cdb_req_q;
  assign rs_free = rs_free_q;

endmodule

// File: tb/tb_mul_rs_scheduler.sv
module tb_mul_rs_scheduler;
  localparam int NUM_RS = 3;

  logic        clk2 = 1'b0;
  logic        rst, flush, cdb_gnt;
  logic [2:0]  rs_valid, rs_ready;
  logic [11:0] rs_func_flat, rs_rd_flat;
  logic [8:0]  rs_rob_flat;
  logic        ex_b, busy, cdb_req;
  logic [1:0]  ex_idx;
  logic [3:0]  ex_func, ex_rd;
  logic [2:0]  ex_rob;
  logic [2:0]  rs_free;

  mul_rs_scheduler dut (
    .clk2(clk2), .rst(rst), .flush(flush),
    .rs_valid(rs_valid), .rs_ready(rs_ready),
    .rs_func_flat(rs_func_flat), .rs_rd_flat(rs_rd_flat), .rs_rob_flat(rs_rob_flat),
    .ex_b(ex_b), .ex_idx(ex_idx), .ex_func(ex_func), .ex_rd(ex_rd), .ex_rob(ex_rob),
    .busy(busy), .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .rs_free(rs_free)
  );

  always #5 clk2 = ~clk2;

  typedef struct {int idx; int func; int rd; int rob; int lat; bit free;} exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input int f, input int rd, input int rob, input bit fr);
    exp_t e;
    e.idx = i; e.func = f; e.rd = rd; e.rob = rob;
    e.lat = (f == 3) ? 4 : 2;
    e.free = fr;
    q.push_back(e);
  endtask

  task automatic set_entry(input int i, input bit v, input logic [3:0] f,
                           input logic [3:0] rd, input logic [2:0] rob);
    rs_valid[i] = v;
    rs_ready[i] = v;
    rs_func_flat[4*i +: 4] = f;
    rs_rd_flat[4*i +: 4]   = rd;
    rs_rob_flat[3*i +: 3]  = rob;
  endtask

  // Counts release pulses at negedges; optionally retires freed entries.
  task automatic run_frees(input int n, input bit clear_each);
    int cnt = 0;
    for (int c = 0; c < 200 && cnt < n; c++) begin
      @(negedge clk2);
      if (rs_free != 0) begin
        cnt++;
        if (clear_each) rs_valid = rs_valid & ~rs_free;
      end
    end
    chk("frees_seen", cnt, n);
  endtask

  task automatic wait_req();
    for (int c = 0; c < 20 && !cdb_req; c++) @(negedge clk2);
    chk("cdb_req_wait", cdb_req, 1);
  endtask

  // Monitor: pairs each issue with the oldest expectation, checks latency,
  // stability of ex_* while busy, and the release pulse.
  int   cyc = 0, issue_cyc = 0;
  bit   have_cur = 0, prev_req = 0;
  exp_t cur;

  always @(posedge clk2) begin
    #1;
    cyc++;
    if (!rst) begin
      if (ex_b) begin
        if (q.size() == 0) chk("unexpected_issue", ex_idx, -1);
        else begin
          cur = q.pop_front();
          have_cur = 1;
          issue_cyc = cyc;
          chk("issue_idx", ex_idx, cur.idx);
          chk("issue_func", ex_func, cur.func);
          chk("issue_rd", ex_rd, cur.rd);
          chk("issue_rob", ex_rob, cur.rob);
        end
      end else if (busy && have_cur) begin
        chk("ex_stable", {ex_idx, ex_func, ex_rd, ex_rob},
            {cur.idx[1:0], cur.func[3:0], cur.rd[3:0], cur.rob[2:0]});
      end
      if (cdb_req && !prev_req && have_cur)
        chk("req_latency", cyc - issue_cyc, cur.lat);
      if (rs_free != 0) begin
        chk("rs_free", rs_free, (have_cur && cur.free) ? (1 << cur.idx) : 0);
        have_cur = 0;
      end
    end
    prev_req = cdb_req;
  end

  initial begin
    rst = 1; flush = 0; cdb_gnt = 0;
    rs_valid = '0; rs_ready = '0;
    rs_func_flat = '0; rs_rd_flat = '0; rs_rob_flat = '0;
    #3;
    chk("reset_ctrl", {ex_b, busy, cdb_req, rs_free}, 0);
    chk("reset_data", {ex_idx, ex_func, ex_rd, ex_rob}, 0);
    @(negedge clk2); rst = 0;

    // 1: single MUL, immediate grant
    cdb_gnt = 1;
    set_entry(0, 1, 4'b0010, 4'd3, 3'd5);
    push(0, 2, 3, 5, 1);
    run_frees(1, 1);
    chk("busy_after_free", busy, 0);

    // 2: DIV on entry 1, grant withheld 3 extra cycles
    cdb_gnt = 0;
    set_entry(1, 1, 4'b0011, 4'd7, 3'd2);
    push(1, 3, 7, 2, 1);
    wait_req();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk2);
      chk("wb_hold_req", cdb_req, 1);
      chk("wb_hold_nofree", rs_free, 0);
    end
    cdb_gnt = 1;
    @(negedge clk2);
    chk("grant_free", rs_free, 3'b010);
    chk("grant_req_drop", cdb_req, 0);
    rs_valid[1] = 0;

    // 3: all entries continuously ready, fresh pointer
    @(negedge clk2); rst = 1;
    @(negedge clk2); rst = 0;
    set_entry(0, 1, 4'b0010, 4'd1, 3'd1);
    set_entry(1, 1, 4'b0011, 4'd2, 3'd2);
    set_entry(2, 1, 4'b0010, 4'd4, 3'd3);
`ifdef MUL_SCHED_FIXED_PRI_EN
    for (int k = 0; k < 4; k++) push(0, 2, 1, 1, 1);
`else
    push(0, 2, 1, 1, 1); push(1, 3, 2, 2, 1); push(2, 2, 4, 3, 1); push(0, 2, 1, 1, 1);
`endif
    run_frees(4, 0);
    rs_valid = '0; rs_ready = '0;

    // 4: non-mul func never issues
    set_entry(2, 1, 4'b0001, 4'd6, 3'd6);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk2);
      chk("nonmul_idle", {busy, ex_b}, 0);
    end
    rs_valid = '0; rs_ready = '0;

    // 5: flush coincident with grant in WB
    cdb_gnt = 0;
    set_entry(1, 1, 4'b0010, 4'd5, 3'd6);
    push(1, 2, 5, 6, 0);
    wait_req();
    cdb_gnt = 1; flush = 1;
    @(negedge clk2);
    chk("flush_req", cdb_req, 0);
    chk("flush_busy", busy, 0);
    chk("flush_nofree", rs_free, 0);
    flush = 0;
    rs_valid[1] = 0; rs_ready[1] = 0;
    set_entry(0, 1, 4'b0010, 4'd8, 3'd0);
    set_entry(2, 1, 4'b0011, 4'd9, 3'd7);
`ifdef MUL_SCHED_FIXED_PRI_EN
    push(0, 2, 8, 0, 1); push(2, 3, 9, 7, 1);
`else
    push(2, 3, 9, 7, 1); push(0, 2, 8, 0, 1);
`endif
    run_frees(2, 1);
    rs_valid = '0; rs_ready = '0;

    // 6: async reset mid-EXEC
    set_entry(0, 1, 4'b0011, 4'd1, 3'd1);
    push(0, 3, 1, 1, 0);
    for (int c = 0; c < 20 && !busy; c++) @(negedge clk2);
    chk("busy_before_rst", busy, 1);
    @(negedge clk2);
    #2 rst = 1;
    #1;
    chk("async_rst", {busy, ex_b, cdb_req}, 0);
    @(negedge clk2); rst = 0;
    set_entry(0, 1, 4'b0010, 4'd3, 3'd4);
    set_entry(1, 1, 4'b0010, 4'd2, 3'd1);
    push(0, 2, 3, 4, 1); push(1, 2, 2, 1, 1);
    run_frees(2, 1);
    rs_valid = '0; rs_ready = '0;

    repeat (3) @(negedge clk2);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mul_rs_scheduler.md
Name: mul_rs_scheduler

Overview:
Issue scheduler for the multiply/divide execution unit of the Tomasulo core. Watches the multiply reservation-station entries, picks one ready entry by round-robin, fires the exec unit's start strobe with the entry's tags, and counts the fixed mul/div latency. It then holds a common-data-bus (CDB) write-back request until granted and releases the reservation-station entry. Only one operation is in flight at a time.

Parameters:
NUM_RS, 3, number of multiply reservation-station entries
IDX_W, 2, width of entry index (ceil log2 NUM_RS)
MUL_LAT, 2, cycles from ex_b to cdb_req for MUL (func 4'b0010), >=1
DIV_LAT, 4, cycles from ex_b to cdb_req for DIV (func 4'b0011), >=1
CNT_W, 3, latency counter width, must hold max(MUL_LAT,DIV_LAT)

Ports:
clk2  in  1  single clock, all state on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous abort of in-flight op (branch mispredict)
rs_valid  in  NUM_RS  entry i occupied
rs_ready  in  NUM_RS  entry i has both operands available
rs_func_flat  in  4*NUM_RS  func of entry i at bits [4i+3:4i]
rs_rd_flat  in  4*NUM_RS  destination register of entry i
rs_rob_flat  in  3*NUM_RS  ROB index of entry i
ex_b  out  1  one-cycle start strobe to the mul exec unit
ex_idx  out  IDX_W  selected entry index (rs_index to exec)
ex_func  out  4  latched func
ex_rd  out  4  latched destination register
ex_rob  out  3  latched ROB index
busy  out  1  op in flight (EXEC or WB)
cdb_req  out  1  write-back request, level until granted
cdb_gnt  in  1  CDB grant
rs_free  out  NUM_RS  one-hot one-cycle pulse freeing entry after write-back

Behaviour:
- Reset (async): state IDLE; ex_b, busy, cdb_req, rs_free = 0; ex_idx, ex_func, ex_rd, ex_rob = 0; rr_ptr = 0; counter = 0.
- eligible[i] = rs_valid[i] & rs_ready[i] & (func == 4'b0010 or 4'b0011). Any other func is never eligible and is never freed by this block.
- FSM states: IDLE, EXEC, WB.
- IDLE: if any eligible and !flush, select the first eligible index searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_RS. Latch idx/func/rd/rob, set rr_ptr = (idx+1) mod NUM_RS, load counter with MUL_LAT or DIV_LAT by func, go to EXEC. ex_b = 1 for exactly the first EXEC cycle.
- EXEC: counter decrements each cycle. cdb_req rises exactly LAT cycles after the ex_b cycle, i.e. ex_b at cycle T gives cdb_req at cycle T+LAT. The state enters WB at that edge.
- WB: cdb_req held at 1 with ex_* stable until cdb_gnt is sampled 1 at a rising edge. At that edge: cdb_req drops, rs_free[ex_idx] pulses for one cycle, state returns to IDLE.
- No issue on the grant edge. Minimum one IDLE cycle between ops, so the back-to-back issue interval is LAT+2 cycles when the grant is immediate.
- busy = 1 in EXEC and WB.
- cdb_gnt while not in WB is ignored.
- Input changes to the selected entry after issue are ignored; ex_* remain latched.
- flush (sync, highest priority after rst): any state goes to IDLE next edge.
  - cdb_req and ex_b drop.
  - No rs_free pulse.
  - rr_ptr retained.
  - A flush coincident with cdb_gnt in WB wins: no rs_free.
- Reset mid-operation: immediate return to reset values, no pulses.

Optional Feature:
Macro MUL_SCHED_FIXED_PRI_EN.
- Defined: fixed priority, lowest eligible index always wins; rr_ptr is not implemented.
- Undefined (default): round-robin as above.

Test Plan:
- Reset, entry 0 valid+ready func 0010 rob 5 rd 3 -> ex_b at cycle T with ex_idx 0, ex_rob 5, ex_rd 3; cdb_req at T+2; gnt held 1 -> rs_free = 3'b001 one cycle; busy 0 after.
- Entry 1 DIV func 0011, cdb_gnt withheld 3 cycles -> cdb_req at T+4, stays high with ex_* stable for 3 extra cycles; rs_free = 3'b010 on the grant edge only.
- All 3 entries ready continuously, immediate grants -> issue order 0,1,2,0 (round-robin); with MUL_SCHED_FIXED_PRI_EN and entry 0 staying ready -> always 0.
- Entry 2 valid+ready func 0001, others invalid -> no ex_b, busy stays 0 for 10 cycles.
- Flush asserted in WB together with cdb_gnt -> next cycle IDLE, cdb_req 0, rs_free 0, rr_ptr unchanged.
- rst asserted mid-EXEC without a clock edge -> busy, ex_b, cdb_req go 0 immediately; after release, a ready entry 0 is issued first.
